// File: rtl/seven_segment_mux.sv
// Multiplexed hex seven-segment driver: scans NUM_SEGMENTS digits onto a shared
// cathode bus with PWM brightness, per-digit enable/blink and leading-zero blanking.
module seven_segment_mux #(
  parameter int NUM_SEGMENTS       = 8,
  parameter int CLK_PER            = 10,
  parameter int REFR_RATE          = 1000,
  parameter int BRIGHT_BITS        = 4,
  parameter int BLINK_HZ           = 2,
  parameter bit ANODE_ACTIVE_LOW   = 1'b1,
  parameter bit CATHODE_ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SEGMENTS-1:0][3:0] encoded,
  input  logic [NUM_SEGMENTS-1:0]      decimal,
  input  logic [NUM_SEGMENTS-1:0]      digit_en,
  input  logic [NUM_SEGMENTS-1:0]      blink,
  input  logic                         blank_lz,
  input  logic [BRIGHT_BITS-1:0]       brightness,
  output logic [NUM_SEGMENTS-1:0]      anode,
  output logic [7:0]                   cathode
);

  localparam longint unsigned NS_PER_S = 64'd1_000_000_000;
  localparam longint unsigned INTERVAL_RAW =
    NS_PER_S / (64'(CLK_PER) * 64'(REFR_RATE) * 64'(NUM_SEGMENTS));
  localparam longint unsigned BLINK_RAW =
    NS_PER_S / (64'(CLK_PER) * 64'(BLINK_HZ) * 64'd2);
  localparam int unsigned INTERVAL   = (INTERVAL_RAW == 0) ? 32'd1 : 32'(INTERVAL_RAW);
  localparam int unsigned BLINK_HALF = (BLINK_RAW == 0) ? 32'd1 : 32'(BLINK_RAW);

  localparam int SLOT_W  = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IDX_W   = $clog2(NUM_SEGMENTS);

  localparam logic [SLOT_W-1:0]       SLOT_LAST  = SLOT_W'(INTERVAL - 1);
  localparam logic [BLINK_W-1:0]      BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(NUM_SEGMENTS - 1);
  // Polarity masks: XOR an active-high pattern with these at the output register.
  localparam logic [NUM_SEGMENTS-1:0] ANODE_OFF  = {NUM_SEGMENTS{ANODE_ACTIVE_LOW}};
  localparam logic [7:0]              CATH_OFF   = {8{CATHODE_ACTIVE_LOW}};

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_off;

  logic [NUM_SEGMENTS-1:0] suppress;
  logic                    zero_above;
  logic [NUM_SEGMENTS-1:0] sel_onehot;
  logic [3:0]              enc_sel;
  logic                    dp_sel;
  logic                    en_sel;
  logic                    blink_sel;
  logic                    supp_sel;
  logic [63:0]             pwm_thr;
  logic                    pwm_on;
  logic                    lit;
  logic [6:0]              seg_on;
  logic [NUM_SEGMENTS-1:0] anode_nxt;
  logic [7:0]              cathode_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Walk from the most significant digit down; a digit is blanked while every digit at or above it is zero.
  always_comb begin
    zero_above = 1'b1;
    suppress   = '0;
    for (int i = NUM_SEGMENTS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (encoded[i] == 4'h0);
      suppress[i] = blank_lz & zero_above & (i != 0);
    end
  end

  always_comb begin
    sel_onehot = '0;
    enc_sel    = 4'h0;
    dp_sel     = 1'b0;
    en_sel     = 1'b0;
    blink_sel  = 1'b0;
    supp_sel   = 1'b0;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        enc_sel       = encoded[i];
        dp_sel        = decimal[i];
        en_sel        = digit_en[i];
        blink_sel     = blink[i];
        supp_sel      = suppress[i];
      end
    end
  end

  assign pwm_thr = (64'(INTERVAL) * 64'(brightness)) >> BRIGHT_BITS;
  assign pwm_on  = (brightness == '1) || (64'(slot_cnt) < pwm_thr);
  assign lit     = en_sel && !(blink_sel && blink_off) && (brightness != '0) && pwm_on;

  always_comb begin
    seg_on      = supp_sel ? 7'h00 : hex_to_seg(enc_sel);
    cathode_nxt = lit ? ({dp_sel, seg_on} ^ CATH_OFF) : CATH_OFF;
    anode_nxt   = sel_onehot ^ ANODE_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
      anode     <= ANODE_OFF;
      cathode   <= CATH_OFF;
    end else begin
      anode   <= anode_nxt;
      cathode <= cathode_nxt;
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux: 4-digit main instance, a 6-digit active-high-anode
// instance, and a 2-digit instance whose slot is a single cycle.
module tb_seven_segment_mux;

  logic clk;
  logic rst;

  // Main instance: 4 digits, INTERVAL = 10, BLINK_HALF = 50.
  logic [3:0][3:0] enc4;
  logic [3:0]      dec4, en4, blk4;
  logic            blz4;
  logic [3:0]      br4;
  logic [3:0]      an4;
  logic [7:0]      ca4;

  // 6 digits, INTERVAL = 6, anodes active-high.
  logic [5:0][3:0] enc6;
  logic [5:0]      dec6, en6, blk6;
  logic            blz6;
  logic [3:0]      br6;
  logic [5:0]      an6;
  logic [7:0]      ca6;

  // 2 digits, INTERVAL = 1.
  logic [1:0][3:0] enc2;
  logic [1:0]      dec2, en2, blk2;
  logic            blz2;
  logic [3:0]      br2;
  logic [1:0]      an2;
  logic [7:0]      ca2;

  int n_vec;
  int n_err;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_segment_mux #(
    .NUM_SEGMENTS(4), .CLK_PER(10), .REFR_RATE(2_500_000), .BRIGHT_BITS(4),
    .BLINK_HZ(1_000_000), .ANODE_ACTIVE_LOW(1'b1), .CATHODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .encoded(enc4), .decimal(dec4), .digit_en(en4),
    .blink(blk4), .blank_lz(blz4), .brightness(br4), .anode(an4), .cathode(ca4)
  );

  seven_segment_mux #(
    .NUM_SEGMENTS(6), .CLK_PER(10), .REFR_RATE(2_500_000), .BRIGHT_BITS(4),
    .BLINK_HZ(1_000_000), .ANODE_ACTIVE_LOW(1'b0), .CATHODE_ACTIVE_LOW(1'b1)
  ) dut6 (
    .clk(clk), .rst(rst), .encoded(enc6), .decimal(dec6), .digit_en(en6),
    .blink(blk6), .blank_lz(blz6), .brightness(br6), .anode(an6), .cathode(ca6)
  );

  seven_segment_mux #(
    .NUM_SEGMENTS(2), .CLK_PER(10), .REFR_RATE(50_000_000), .BRIGHT_BITS(4),
    .BLINK_HZ(2), .ANODE_ACTIVE_LOW(1'b1), .CATHODE_ACTIVE_LOW(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .encoded(enc2), .decimal(dec2), .digit_en(en2),
    .blink(blk2), .blank_lz(blz2), .brightness(br2), .anode(an2), .cathode(ca2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low cathode byte for hex value v with optional dp.
  function automatic logic [7:0] exp_cath(input logic [3:0] v, input logic dp);
    exp_cath = ~{dp, seg_tab[v]};
  endfunction

  // Pulses reset for one cycle; returns on the negedge where rst drops, so the
  // next negedge observes the outputs for scan state (digit 0, slot 0).
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (an4 !== 4'b1111) begin
        n_err++; $display("FAIL reset_anode c=%0d got=%b exp=%b", c, an4, 4'b1111);
      end
      n_vec++;
      if (ca4 !== 8'hFF) begin
        n_err++; $display("FAIL reset_cathode c=%0d got=%h exp=%h", c, ca4, 8'hFF);
      end
      n_vec++;
      if (an6 !== 6'b000000) begin
        n_err++; $display("FAIL reset_anode6 c=%0d got=%b exp=%b", c, an6, 6'b000000);
      end
    end
    rst = 1'b0;
  endtask

  // Straight after test_reset: digits 1,2,3,4 at full brightness, 10 cycles each, wrapping at 40.
  task automatic test_scan();
    logic [3:0] ea;
    logic [7:0] ec;
    int d;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      d  = (k / 10) % 4;
      ea = ~(4'b0001 << d);
      ec = exp_cath(4'(d + 1), 1'b0);
      n_vec++;
      if (an4 !== ea) begin
        n_err++; $display("FAIL scan_anode k=%0d got=%b exp=%b", k, an4, ea);
      end
      n_vec++;
      if (ca4 !== ec) begin
        n_err++; $display("FAIL scan_cathode k=%0d got=%h exp=%h", k, ca4, ec);
      end
    end
  endtask

  task automatic test_pwm();
    logic [3:0] ea;
    logic [7:0] ec;
    int d;
    br4 = 4'h8;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      if (k == 40) br4 = 4'h0;
      @(negedge clk);
      d  = (k / 10) % 4;
      ea = ~(4'b0001 << d);
      if (k < 40 && (k % 10) < 5) ec = exp_cath(4'(d + 1), 1'b0);
      else                        ec = 8'hFF;
      n_vec++;
      if (an4 !== ea) begin
        n_err++; $display("FAIL pwm_anode k=%0d got=%b exp=%b", k, an4, ea);
      end
      n_vec++;
      if (ca4 !== ec) begin
        n_err++; $display("FAIL pwm_cathode k=%0d br=%h got=%h exp=%h", k, br4, ca4, ec);
      end
    end
    br4 = 4'hF;
  endtask

  task automatic test_leading_zero();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    logic [7:0] ec;
    exp_a = '{8'h92, 8'hFF, 8'h7F, 8'hFF};
    exp_b = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    blz4 = 1'b1;
    enc4 = {4'h0, 4'h0, 4'h0, 4'h5};
    dec4 = 4'b0100;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ec = exp_a[k / 10];
      n_vec++;
      if (ca4 !== ec) begin
        n_err++; $display("FAIL lz_cathode k=%0d got=%h exp=%h", k, ca4, ec);
      end
    end
    enc4 = 16'h0000;
    dec4 = 4'b0000;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ec = exp_b[k / 10];
      n_vec++;
      if (ca4 !== ec) begin
        n_err++; $display("FAIL lz_zero_cathode k=%0d got=%h exp=%h", k, ca4, ec);
      end
    end
    blz4 = 1'b0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_vec++;
      if (ca4 !== 8'hC0) begin
        n_err++; $display("FAIL lz_off_cathode k=%0d got=%h exp=%h", k, ca4, 8'hC0);
      end
    end
  endtask

  task automatic test_blink_enable();
    logic [7:0] ec;
    int d;
    int boff;
    enc4 = {4'h4, 4'h3, 4'h2, 4'h1};
    dec4 = 4'b1111;
    en4  = 4'b1011;
    blk4 = 4'b0010;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      d    = (k / 10) % 4;
      boff = (k / 50) % 2;
      if (d == 2 || (d == 1 && boff == 1)) ec = 8'hFF;
      else                                 ec = exp_cath(4'(d + 1), 1'b1);
      n_vec++;
      if (ca4 !== ec) begin
        n_err++; $display("FAIL blink_cathode k=%0d digit=%0d got=%h exp=%h", k, d, ca4, ec);
      end
    end
    dec4 = 4'b0000;
    en4  = 4'b1111;
    blk4 = 4'b0000;
  endtask

  task automatic test_six_digits();
    logic [5:0] ea;
    logic [7:0] ec;
    int d;
    do_reset();
    for (int k = 0; k <= 72; k++) begin
      @(negedge clk);
      d  = (k / 6) % 6;
      ea = 6'b000001 << d;
      ec = exp_cath(4'(10 + d), 1'b0);
      n_vec++;
      if (an6 !== ea) begin
        n_err++; $display("FAIL six_anode k=%0d got=%b exp=%b", k, an6, ea);
      end
      n_vec++;
      if (ca6 !== ec) begin
        n_err++; $display("FAIL six_cathode k=%0d got=%h exp=%h", k, ca6, ec);
      end
    end
  endtask

  task automatic test_interval_one();
    logic [1:0] ea;
    logic [7:0] ec;
    br2 = 4'hF;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k == 8) br2 = 4'h8;
      @(negedge clk);
      ea = (k % 2 == 0) ? 2'b10 : 2'b01;
      if (k >= 8)          ec = 8'hFF;
      else if (k % 2 == 0) ec = 8'hC0;
      else                 ec = 8'hF8;
      n_vec++;
      if (an2 !== ea) begin
        n_err++; $display("FAIL int1_anode k=%0d got=%b exp=%b", k, an2, ea);
      end
      n_vec++;
      if (ca2 !== ec) begin
        n_err++; $display("FAIL int1_cathode k=%0d got=%h exp=%h", k, ca2, ec);
      end
    end
    br2 = 4'hF;
  endtask

  task automatic test_mid_reset();
    logic [3:0] ea;
    int d;
    do_reset();
    for (int k = 0; k < 25; k++) @(negedge clk);
    n_vec++;
    if (an4 !== 4'b1011) begin
      n_err++; $display("FAIL midrst_pre_anode got=%b exp=%b", an4, 4'b1011);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (an4 !== 4'b1111) begin
      n_err++; $display("FAIL midrst_anode got=%b exp=%b", an4, 4'b1111);
    end
    n_vec++;
    if (ca4 !== 8'hFF) begin
      n_err++; $display("FAIL midrst_cathode got=%h exp=%h", ca4, 8'hFF);
    end
    n_vec++;
    if (an6 !== 6'b000000) begin
      n_err++; $display("FAIL midrst_anode6 got=%b exp=%b", an6, 6'b000000);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      d  = k / 10;
      ea = ~(4'b0001 << d);
      n_vec++;
      if (an4 !== ea) begin
        n_err++; $display("FAIL midrst_scan_anode k=%0d got=%b exp=%b", k, an4, ea);
      end
      if (k < 6) begin
        n_vec++;
        if (an6 !== 6'b000001) begin
          n_err++; $display("FAIL midrst_anode6 k=%0d got=%b exp=%b", k, an6, 6'b000001);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    enc4  = {4'h4, 4'h3, 4'h2, 4'h1};
    dec4  = 4'b0000;
    en4   = 4'b1111;
    blk4  = 4'b0000;
    blz4  = 1'b0;
    br4   = 4'hF;
    enc6  = {4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    dec6  = '0;
    en6   = '1;
    blk6  = '0;
    blz6  = 1'b0;
    br6   = 4'hF;
    enc2  = {4'h7, 4'h0};
    dec2  = '0;
    en2   = '1;
    blk2  = '0;
    blz2  = 1'b0;
    br2   = 4'hF;

    test_reset();
    test_scan();
    test_pwm();
    test_leading_zero();
    test_blink_enable();
    test_six_digits();
    test_interval_one();
    test_mid_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
Name: seven_segment_mux

Overview:
Next-generation multiplexed seven-segment display driver. It time-multiplexes NUM_SEGMENTS hex digits onto a shared cathode bus with a synchronous reset. Over the previous driver it adds selectable anode/cathode polarity, non-power-of-2 digit counts, PWM brightness, per-digit enable/blink and leading-zero suppression. It sits between the board top level and the display pins, with the hex decode built in.

Parameters:
NUM_SEGMENTS, 8, number of digits (>=2, need not be a power of 2)
CLK_PER, 10, clock period in ns
REFR_RATE, 1000, full-frame refresh rate in Hz
BRIGHT_BITS, 4, brightness control width
BLINK_HZ, 2, blink rate in Hz (on+off period)
ANODE_ACTIVE_LOW, 1, 1 = anode driven 0 when selected
CATHODE_ACTIVE_LOW, 1, 1 = segment driven 0 when lit

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
encoded  in  NUM_SEGMENTS x 4  hex value per digit; index 0 = least significant (rightmost)
decimal  in  NUM_SEGMENTS  decimal point request per digit
digit_en  in  NUM_SEGMENTS  1 = digit may light; 0 = digit dark including dp
blink  in  NUM_SEGMENTS  1 = digit dark during blink-off phase
blank_lz  in  1  leading-zero suppression enable
brightness  in  BRIGHT_BITS  duty control; 0 = dark, all-ones = full on
anode  out  NUM_SEGMENTS  digit select, registered
cathode  out  8  segments {dp,g,f,e,d,c,b,a} (bit7 = dp), registered

Behaviour:
- One clock, clk. rst is synchronous, active-high and dominates all other activity.
- Derived constants (integer division, each clamped to >=1):
  - INTERVAL = 1e9 / (CLK_PER * REFR_RATE * NUM_SEGMENTS) cycles per digit slot.
  - BLINK_HALF = 1e9 / (CLK_PER * BLINK_HZ * 2) cycles per blink phase.
- Reset values:
  - slot_cnt = 0, digit_idx = 0, blink_cnt = 0, blink_off = 0.
  - anode = all inactive (all ones if ANODE_ACTIVE_LOW, else all zeros).
  - cathode = all segments off (polarity-adjusted).
  - Reset applied mid-frame takes effect on the next edge, with no partial-digit glitch.
- Slot counter:
  - slot_cnt counts 0..INTERVAL-1.
  - At INTERVAL-1 it wraps to 0 and digit_idx increments.
  - digit_idx wraps from NUM_SEGMENTS-1 to 0; the full set of index values is 0..NUM_SEGMENTS-1, and other values never occur.
- Blink counter: blink_cnt counts 0..BLINK_HALF-1. On wrap, blink_off toggles. It is free-running and independent of the slot counter.
- Decode (active-high pattern before polarity), hex 0-F:
  3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71. dp = decimal[i].
- Leading-zero rule: when blank_lz = 1, digit i (i>0) is suppressed if encoded[j] == 0 for every j >= i.
  - A suppressed digit shows only its dp, if decimal[i] is set.
  - Digit 0 is never suppressed.
- Lit condition for the selected digit i (all must hold):
  - digit_en[i] = 1;
  - not (blink[i] and blink_off);
  - brightness != 0;
  - and either brightness is all-ones, or slot_cnt < ((INTERVAL * brightness) >> BRIGHT_BITS).
  - If not lit: cathode = all off. The anode stays selected, so the dark time is uniform across digits.
- Output timing:
  - anode and cathode are registered.
  - The values for state (digit_idx, slot_cnt) appear one cycle later.
  - anode and cathode always change on the same edge, so no cross-digit ghosting.
- Polarity:
  - anode: exactly one bit is active, at digit_idx, after the reset-exit cycle.
  - Polarity inversion is applied at the output register only.
- Inputs are sampled every cycle. A change takes effect no later than the next cycle; there is no frame-level latching.
- Boundary cases:
  - brightness change mid-slot: comparison uses the current value.
  - blink_off toggling mid-slot: the digit goes dark or lit on the next edge.
  - INTERVAL = 1: the digit advances every cycle, and PWM degenerates to on/off.

Test Plan:
(Sim parameters unless stated: NUM_SEGMENTS=4, CLK_PER=10, REFR_RATE=2_500_000 (INTERVAL=10), BLINK_HZ=1_000_000 (BLINK_HALF=50), BRIGHT_BITS=4, both polarities active-low.)
1. rst high 3 cycles, then low; encoded=4'h1,2,3,4 (digits 0..3), brightness=F, all digit_en=1.
   - During reset: anode=4'b1111, cathode=8'hFF.
   - After reset: anode=1110 for 10 cycles with cathode=~8'h06, then 1101 with ~8'h5B, etc.
   - Wraps back to digit 0 after 40 cycles.
2. brightness=4'h8, INTERVAL=10 -> each slot lit 5 cycles (cathode=~pattern), then dark 5 cycles (8'hFF). brightness=0 -> cathode stays 8'hFF, anode still scans.
3. blank_lz=1, encoded={0,0,0,5} (digit3..0), decimal[2]=1.
   - Digit3 cathode=8'hFF.
   - Digit2 cathode=8'h7F (dp only).
   - Digit1 dark.
   - Digit0 shows ~8'h6D.
   - All zeros: digit 0 shows ~8'h3F.
4. blink[1]=1 -> digit1 dark for 50 cycles, lit for 50 cycles, alternating; other digits unaffected. digit_en[2]=0 -> digit2 always 8'hFF, dp included.
5. NUM_SEGMENTS=6 -> anode sequence covers 6 one-cold codes, then returns to 111110; index never reaches 6 or 7.
6. rst asserted mid-slot on digit 2 -> next edge: anode all inactive, cathode 8'hFF; scan restarts at digit 0 with a full 10-cycle slot. Repeat with ANODE_ACTIVE_LOW=0 -> anode=0000 in reset, one-hot 0001 on digit 0.
